kanagawa_skid_fifo_write_buffer: RTL and testbench

// - Write-side counterpart of the skid read buffer. It sits between a producer
//   and the write port of an existing FIFO.
// - Presents a fully registered full_out to the producer, so there is no

---
 rtl/kanagawa_skid_fifo_write_buffer.sv | 84 ++++++++
 tb/tb_kanagawa_skid_fifo_write_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_skid_fifo_write_buffer.sv
// Write-side skid buffer between a producer and a FIFO write port.
// full_out is a flop, so timing from the FIFO full flag never reaches the producer.
module kanagawa_skid_fifo_write_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrreq_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             full_out,
  output logic             wrreq_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             full_in,
  output logic             overflow_out
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign wrreq_out    = wrreq_in;
    assign data_out     = data_in;
    assign full_out     = full_in;
    assign overflow_out = 1'b0;
  end else begin : g_skid
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             push, pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      push     = wrreq_in & ~full_q;
      pop      = (count_q != '0) & ~full_in;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      full_d   = (count_d == CNT_W'(DEPTH));
      ovf_d    = ovf_q | (wrreq_in & full_q);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        full_q   <= full_d;
        ovf_q    <= ovf_d;
      end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign wrreq_out    = pop;
    assign data_out     = mem_q[rd_ptr_q];
    assign full_out     = full_q;
    assign overflow_out = ovf_q;
  end

endmodule

// File: tb/tb_kanagawa_skid_fifo_write_buffer.sv
// Bench for the skid write buffer: DEPTH 2, 3 and 0 instances share one stimulus
// and a queue-based reference model tracks the instance under test.
module tb_kanagawa_skid_fifo_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrreq_in;
  logic [15:0] data_in;
  logic        full_in;

  logic        full_out_d2, wrreq_out_d2, overflow_out_d2;
  logic [15:0] data_out_d2;
  logic        full_out_d3, wrreq_out_d3, overflow_out_d3;
  logic [15:0] data_out_d3;
  logic        full_out_d0, wrreq_out_d0, overflow_out_d0;
  logic [15:0] data_out_d0;

  always #5 clk = ~clk;

  kanagawa_skid_fifo_write_buffer #(.WIDTH(16), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .wrreq_in(wrreq_in), .data_in(data_in),
    .full_out(full_out_d2), .wrreq_out(wrreq_out_d2), .data_out(data_out_d2),
    .full_in(full_in), .overflow_out(overflow_out_d2));

  kanagawa_skid_fifo_write_buffer #(.WIDTH(16), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .wrreq_in(wrreq_in), .data_in(data_in),
    .full_out(full_out_d3), .wrreq_out(wrreq_out_d3), .data_out(data_out_d3),
    .full_in(full_in), .overflow_out(overflow_out_d3));

  kanagawa_skid_fifo_write_buffer #(.WIDTH(16), .DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .wrreq_in(wrreq_in), .data_in(data_in),
    .full_out(full_out_d0), .wrreq_out(wrreq_out_d0), .data_out(data_out_d0),
    .full_in(full_in), .overflow_out(overflow_out_d0));

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus the registered full and sticky overflow.
  int          mdepth;
  logic [15:0] mq[$];
  bit          mfull;
  bit          movf;

  logic [15:0] got[$];
  int          emitted_n;
  logic        last_ovf;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic sel_outputs(output logic o_wr, output logic [15:0] o_data,
                             output logic o_full, output logic o_ovf);
    if (mdepth == 2) begin
      o_wr = wrreq_out_d2; o_data = data_out_d2; o_full = full_out_d2; o_ovf = overflow_out_d2;
    end else begin
      o_wr = wrreq_out_d3; o_data = data_out_d3; o_full = full_out_d3; o_ovf = overflow_out_d3;
    end
  endtask

  // One clock cycle: drive, compare on the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic wr, input logic [15:0] d, input logic fin);
    logic        o_wr, o_full, o_ovf;
    logic [15:0] o_data;
    bit          exp_pop;
    wrreq_in = wr;
    data_in  = d;
    full_in  = fin;
    @(negedge clk);
    sel_outputs(o_wr, o_data, o_full, o_ovf);
    exp_pop = (mq.size() != 0) && !fin;
    check("wrreq_out", {31'd0, o_wr}, {31'd0, exp_pop});
    if (exp_pop) check("data_out", {16'd0, o_data}, {16'd0, mq[0]});
    check("full_out", {31'd0, o_full}, {31'd0, mfull});
    check("overflow_out", {31'd0, o_ovf}, {31'd0, movf});
    check("pass_wrreq", {31'd0, wrreq_out_d0}, {31'd0, wr});
    check("pass_data", {16'd0, data_out_d0}, {16'd0, d});
    check("pass_full", {31'd0, full_out_d0}, {31'd0, fin});
    check("pass_ovf", {31'd0, overflow_out_d0}, 32'd0);
    if (o_wr) begin
      got.push_back(o_data);
      emitted_n++;
    end
    last_ovf = o_ovf;
    if (exp_pop) void'(mq.pop_front());
    if (wr) begin
      if (mfull) movf = 1'b1;
      else       mq.push_back(d);
    end
    mfull = (mq.size() == mdepth);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_wrreq_d2"}, {31'd0, wrreq_out_d2}, 32'd0);
    check({tag, "_full_d2"}, {31'd0, full_out_d2}, 32'd0);
    check({tag, "_ovf_d2"}, {31'd0, overflow_out_d2}, 32'd0);
    check({tag, "_wrreq_d3"}, {31'd0, wrreq_out_d3}, 32'd0);
    check({tag, "_full_d3"}, {31'd0, full_out_d3}, 32'd0);
    check({tag, "_ovf_d3"}, {31'd0, overflow_out_d3}, 32'd0);
    mq.delete();
    mfull = 1'b0;
    movf  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int accepted;
    int cyc;
    logic wr_r;

    rst      = 1'b1;
    wrreq_in = 1'b0;
    data_in  = '0;
    full_in  = 1'b0;
    mdepth   = 2;
    mfull    = 1'b0;
    movf     = 1'b0;
    emitted_n = 0;
    #1;
    check("rst_wrreq", {31'd0, wrreq_out_d2}, 32'd0);
    check("rst_full", {31'd0, full_out_d2}, 32'd0);
    check("rst_ovf", {31'd0, overflow_out_d2}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stream of 16 words at full rate.
    got.delete();
    for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    check("stream_n", got.size(), 32'd16);
    for (int i = 0; i < 16; i++) check("stream_word", {16'd0, got[i]}, i + 1);

    // Backpressure then release.
    got.delete();
    step(1'b1, 16'hA, 1'b1);
    step(1'b1, 16'hB, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    check("bp_n", got.size(), 32'd2);
    check("bp_0", {16'd0, got[0]}, 32'hA);
    check("bp_1", {16'd0, got[1]}, 32'hB);

    // Overflow: third write while full is dropped, flag is sticky.
    got.delete();
    step(1'b1, 16'hA, 1'b1);
    step(1'b1, 16'hB, 1'b1);
    step(1'b1, 16'hC, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0);
    check("ovf_n", got.size(), 32'd2);
    check("ovf_0", {16'd0, got[0]}, 32'hA);
    check("ovf_1", {16'd0, got[1]}, 32'hB);
    check("ovf_sticky", {31'd0, last_ovf}, 32'd1);

    // Reset while holding two words.
    step(1'b1, 16'h1, 1'b1);
    step(1'b1, 16'h2, 1'b1);
    async_reset("midrst");
    got.delete();
    step(1'b1, 16'h5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    check("midrst_n", got.size(), 32'd1);
    check("midrst_0", {16'd0, got[0]}, 32'h5);

    // DEPTH=3: random pushes gated by full_out, random backpressure.
    mdepth = 3;
    async_reset("d3rst");
    emitted_n = 0;
    accepted  = 0;
    cyc       = 0;
    while (accepted < 1000 && cyc < 8000) begin
      wr_r = ($urandom_range(0, 1) == 1) && !full_out_d3;
      if (wr_r) accepted++;
      step(wr_r, 16'($urandom), ($urandom_range(0, 1) == 1));
      cyc++;
    end
    check("rand_done", {31'd0, accepted >= 1000}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
    check("rand_emitted", emitted_n, accepted);

    // Ungated random stimulus: pass-through instance and overflow path.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 1) == 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
